pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  processor main clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: stall  input  1  downstream hold; output slot not consumed this cycle.
REQ-005 Port: redirect  input  1  branch/jump taken; flush and restart fetch.
REQ-006 Port: redirect_pc  input  32  new fetch address; bits[1:0] ignored.
REQ-007 Port: imem_req  output  1  instruction memory request.
REQ-008 Port: imem_addr  output  32  fetch address, word aligned.
REQ-009 Port: imem_ack  input  1  memory response valid, sampled on the rising edge while imem_req=1.
REQ-010 Port: imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 Port: pc  output  32  PC of the presented instruction; feeds the PC pipeline register.
REQ-012 Port: instr  output  32  presented instruction.
REQ-013 Port: valid  output  1  pc/instr hold a live instruction.
REQ-014 Port: nop  output  1  bubble indicator for the downstream PC pipeline; equals ~valid.

Function
REQ-015 Internal state: fetch_pc (32 bits), skid register (pc+instr), FSM states IDLE, FETCH, HOLD, DROP.
REQ-016 IDLE: imem_req=0; next edge -> FETCH unconditionally.
REQ-017 FETCH: imem_req=1, imem_addr=fetch_pc; imem_addr stays stable until the request is acked.
REQ-018 FETCH, ack=1, redirect=1: discard rdata; fetch_pc<=redirect_pc&~3; valid<=0; stay FETCH.
REQ-019 FETCH, ack=1, redirect=0, stall=0: pc<=fetch_pc, instr<=rdata, valid<=1; fetch_pc+=4; stay FETCH.
REQ-020 FETCH, ack=1, redirect=0, stall=1: skid<=(fetch_pc, rdata); fetch_pc+=4; outputs held; -> HOLD.
REQ-021 FETCH, ack=0, redirect=1: fetch_pc<=redirect_pc&~3; valid<=0; -> DROP.
REQ-022 FETCH, ack=0, redirect=0: stall=0 -> valid<=0; stall=1 -> outputs held.
REQ-023 DROP: imem_req=1 with the old address; on ack discard rdata -> FETCH; a further redirect only updates fetch_pc.
REQ-024 HOLD: imem_req=0; redirect=1 -> clear skid, valid<=0, fetch_pc<=redirect_pc&~3, -> FETCH; else stall=0 -> outputs<=skid, valid<=1, -> FETCH; else hold.
REQ-025 Priority: redirect over stall over ack; a redirect always clears valid on the same edge.
REQ-026 fetch_pc increment wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-027 Throughput: one instruction per cycle with a zero-wait memory; latency imem_req to valid = 1 edge.
REQ-028 Outputs pc, instr, and valid are registered; nop is ~valid, derived combinationally from a register only.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, fetch_pc=RESET_PC, pc=0, instr=32'h0000_0013, valid=0, nop=1, imem_req=0, skid cleared.
REQ-030 Reset asserted mid-request abandons the request; no ack is expected or consumed after reset release.
REQ-031 First imem_req rises one edge after rst deasserts.

Structure
REQ-032 Shared package: RESET_PC default, NOP_INSTR (32'h0000_0013), FSM state encodings, and PC_STEP (4).
REQ-033 Sub-module: fetch_skid_buffer (one-entry pc+instr holding register with load/clear).

Verification
REQ-034 Reset release, memory acks every cycle, stall=0 -> addresses 0,4,8,C. valid is first high one edge after the first ack, and pc follows 0,4,8.
REQ-035 Ack at addr 8 with stall=1 for 3 cycles -> imem_req=0 and outputs frozen at pc=4. When stall drops: pc=8, then the fetch of 0xC resumes.
REQ-036 Request to 0x10 pending with ack delayed 2 cycles, redirect to 0x103 -> DROP state. The 0x10 data is discarded, and the next imem_addr is 0x100.
REQ-037 fetch_pc=0xFFFF_FFFC acked -> next imem_addr=0x0000_0000.
REQ-038 rst pulsed while in HOLD -> valid=0, nop=1, and instr=0x13 immediately. After release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : instruction presented while nothing live is held
//   PC_STEP          : fetch address increment (one 32-bit word)
//   fetch_state_t    : fetch FSM state encoding
//   align_pc()       : forces an address onto a word boundary
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction and its PC.
// Captures a response that arrives while the output slot is stalled.
//   clk, rst              : clock, async active-high reset
//   load                  : capture load_pc / load_instr
//   clear                 : discard the held entry (wins over load)
//   load_pc, load_instr   : entry to capture
//   pc, instr             : held entry
module fetch_skid_buffer
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= 32'h0000_0000;
            instr <= NOP_INSTR;
        end else if (clear) begin
            pc    <= 32'h0000_0000;
            instr <= NOP_INSTR;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches, presents one
// instruction per cycle, absorbs a single response under stall and flushes
// on redirect.
//   clk, rst              : clock, async active-high reset
//   stall                 : downstream not consuming the output slot
//   redirect, redirect_pc : restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req, imem_addr   : instruction memory request / address
//   imem_ack, imem_rdata  : memory response
//   pc, instr, valid      : presented instruction (registered)
//   nop                   : bubble flag, ~valid
//
// state | meaning
// IDLE  | just out of reset, no request; goes to FETCH on the next edge
// FETCH | request to fetch_pc outstanding
// HOLD  | response parked in skid buffer while downstream stalls; no request
// DROP  | redirect hit an unacked request; finish it and discard the data
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        valid,
    output logic        nop
);

    fetch_state_t state_q, state_d;

    logic [31:0] fetch_pc_q;
    // Address of the request being abandoned in DROP; fetch_pc already
    // points at the redirect target, but the bus must keep the old address.
    logic [31:0] drop_addr_q;

    logic        skid_load;
    logic        skid_clear;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    if (!imem_ack) begin
                        state_d = ST_DROP;
                    end
                end else if (imem_ack && stall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect || !stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req   = (state_q == ST_FETCH) || (state_q == ST_DROP);
        imem_addr  = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
        skid_load  = (state_q == ST_FETCH) && imem_ack && !redirect && stall;
        skid_clear = (state_q == ST_HOLD) && redirect;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= 32'h0000_0000;
            pc          <= 32'h0000_0000;
            instr       <= NOP_INSTR;
            valid       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= align_pc(redirect_pc);
                        valid      <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (redirect) begin
                        fetch_pc_q <= align_pc(redirect_pc);
                        valid      <= 1'b0;
                        if (!imem_ack) begin
                            drop_addr_q <= fetch_pc_q;
                        end
                    end else if (imem_ack) begin
                        fetch_pc_q <= fetch_pc_q + PC_STEP;
                        if (!stall) begin
                            pc    <= fetch_pc_q;
                            instr <= imem_rdata;
                            valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        // Slot consumed with nothing to replace it.
                        valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        fetch_pc_q <= align_pc(redirect_pc);
                        valid      <= 1'b0;
                    end else if (!stall) begin
                        pc    <= skid_pc;
                        instr <= skid_instr;
                        valid <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (redirect) begin
                        fetch_pc_q <= align_pc(redirect_pc);
                        valid      <= 1'b0;
                    end
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign nop = ~valid;

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_pc    (fetch_pc_q),
        .load_instr (imem_rdata),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        nop;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .valid       (valid),
        .nop         (nop)
    );

    // Instruction memory contents: every address holds a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // Expected outputs seen at a falling edge, then inputs for the next rise.
    typedef struct packed {
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic a);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_ack    = a;
        imem_rdata  = mem_word(imem_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cycles;

        vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        NOP,                    1'b0, 1'b0, 32'h0,        1'b1};
        vecs[1]  = '{1'b1, 32'h0,        1'b0, 32'h0,        NOP,                    1'b0, 1'b0, 32'h0,        1'b1};
        vecs[2]  = '{1'b1, 32'h4,        1'b1, 32'h0,        mem_word(32'h0),        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[3]  = '{1'b1, 32'h8,        1'b1, 32'h4,        mem_word(32'h4),        1'b1, 1'b0, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'hC,        1'b1, 32'h4,        mem_word(32'h4),        1'b1, 1'b0, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'hC,        1'b1, 32'h4,        mem_word(32'h4),        1'b1, 1'b0, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'hC,        1'b1, 32'h4,        mem_word(32'h4),        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'hC,        1'b1, 32'h8,        mem_word(32'h8),        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h10,       1'b1, 32'hC,        mem_word(32'hC),        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'h10,       1'b0, 32'hC,        mem_word(32'hC),        1'b0, 1'b1, 32'h103,      1'b0};
        vecs[10] = '{1'b1, 32'h10,       1'b0, 32'hC,        mem_word(32'hC),        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'h100,      1'b0, 32'hC,        mem_word(32'hC),        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[12] = '{1'b1, 32'h104,      1'b1, 32'h100,      mem_word(32'h100),      1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1};
        vecs[13] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100,     mem_word(32'h100),      1'b0, 1'b0, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1, 1'b0, 32'h0,      1'b0};
        vecs[15] = '{1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1, 1'b0, 32'h0,      1'b1};
        vecs[16] = '{1'b0, 32'h4,        1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1, 1'b1, 32'h200,    1'b0};
        vecs[17] = '{1'b1, 32'h200,      1'b0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0,      1'b0};
        vecs[18] = '{1'b1, 32'h200,      1'b0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0,      1'b1};
        vecs[19] = '{1'b1, 32'h204,      1'b1, 32'h200,      mem_word(32'h200),      1'b0, 1'b0, 32'h0,        1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_nop", {31'b0, nop}, 32'h1);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        rst = 1'b0;

        // Streaming, stall/skid, delayed-ack redirect, wrap, redirect in HOLD
        for (int i = 0; i < 20; i++) begin
            check($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                check($sformatf("row%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("row%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("row%0d_nop", i), {31'b0, nop}, {31'b0, ~vecs[i].e_valid});
            check($sformatf("row%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("row%0d_instr", i), instr, vecs[i].e_instr);
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].ack);
            @(negedge clk);
        end

        // Second redirect while in DROP only moves the target
        drive(1'b0, 1'b1, 32'h0000_0300, 1'b0);
        @(negedge clk);
        check("drop_addr_held", imem_addr, 32'h204);
        check("drop_valid", {31'b0, valid}, 32'h0);
        drive(1'b0, 1'b1, 32'h0000_0401, 1'b0);
        @(negedge clk);
        check("drop_req", {31'b0, imem_req}, 32'h1);
        check("drop_addr_held2", imem_addr, 32'h204);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("drop_exit_addr", imem_addr, 32'h400);
        check("drop_discard_valid", {31'b0, valid}, 32'h0);

        // Enter HOLD, then reset asynchronously mid-cycle
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("pre_hold_pc", pc, 32'h400);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("hold_req", {31'b0, imem_req}, 32'h0);
        check("hold_valid", {31'b0, valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, valid}, 32'h0);
        check("async_rst_nop", {31'b0, nop}, 32'h1);
        check("async_rst_instr", instr, NOP);
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_req", {31'b0, imem_req}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req", {31'b0, imem_req}, 32'h0);
        cycles = 0;
        while (cycles < 5) begin
            @(posedge clk);
            #1;
            cycles++;
            if (imem_req) break;
        end
        check("first_req_latency", cycles, 32'd1);
        check("first_req_addr", imem_addr, 32'h0);
        check("post_rst_valid", {31'b0, valid}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_first_pc", pc, 32'h0);
        check("post_rst_first_instr", instr, mem_word(32'h0));
        check("post_rst_first_valid", {31'b0, valid}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
